// File: rtl/psram_responder_if.sv
// CRAM pin bundle for one async-mode PSRAM bank. The controller side is the
// master; the device model is the slave. dq_in/dq_out/dq_oe are split so the
// top level can form the tri-state DQ bus.
interface psram_responder_if #(
  parameter int DATA_BITS  = 16,
  parameter int UPPER_BITS = 6
);
  logic [UPPER_BITS-1:0] cram_a;
  logic                  ce_n;
  logic                  adv_n;
  logic                  oe_n;
  logic                  we_n;
  logic                  lb_n;
  logic                  ub_n;
  logic [DATA_BITS-1:0]  dq_in;
  logic [DATA_BITS-1:0]  dq_out;
  logic                  dq_oe;

  modport master (
    output cram_a, ce_n, adv_n, oe_n, we_n, lb_n, ub_n, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  cram_a, ce_n, adv_n, oe_n, we_n, lb_n, ub_n, dq_in,
    output dq_out, dq_oe
  );
endinterface

// File: rtl/psram_responder.sv
// Clocked model of one async-mode PSRAM bank (device end of the CRAM pins).
// Latches the multiplexed address on ce_n=0 & adv_n=0, stores byte-masked
// writes when ce_n rises, and presents read data once ACCESS_CYCLES edges have
// elapsed since the latch.
// Optional protocol checker: define PSRAM_RESPONDER_CHECK_EN.
module psram_responder #(
  parameter int                   DATA_BITS        = 16,
  parameter int                   UPPER_BITS       = 6,
  parameter int                   MEM_ADDRESS_BITS = 10,
  parameter int                   ACCESS_CYCLES    = 2,
  parameter logic [DATA_BITS-1:0] INVALID_PATTERN  = 16'hDEAD
) (
  input  logic              clk,
  input  logic              reset_n,
  psram_responder_if.slave  bus,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              protocol_error
);

  localparam int MEM_WORDS = 1 << MEM_ADDRESS_BITS;
  localparam int ACC_W     = $clog2(ACCESS_CYCLES + 1);
  localparam int LO_BITS   = DATA_BITS / 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                       r_state, w_next;
  logic [MEM_ADDRESS_BITS-1:0]  r_addr;
  logic [ACC_W-1:0]             r_acc;
  logic [DATA_BITS-1:0]         r_rd_word;
  logic [DATA_BITS-1:0]         r_data;
  logic [1:0]                   r_be;
  logic                         r_have_data;
  logic [DATA_BITS-1:0]         r_mem [0:MEM_WORDS-1];

  logic [UPPER_BITS+DATA_BITS-1:0] w_full_addr;
  logic [MEM_ADDRESS_BITS-1:0]     w_lat_addr;
  logic                            w_latch;
  logic                            w_acc_done;
  logic                            w_commit;
  logic                            w_unused_addr;

  // Full address is {upper pins, DQ}; only the low bits index the array, so
  // higher addresses alias onto stored words.
  assign w_full_addr   = {bus.cram_a, bus.dq_in};
  assign w_lat_addr    = w_full_addr[MEM_ADDRESS_BITS-1:0];
  assign w_unused_addr = ^w_full_addr;

  // Address latch in IDLE, or a re-latch that restarts the current access.
  assign w_latch    = !bus.ce_n && !bus.adv_n;
  assign w_acc_done = (r_acc >= ACC_W'(ACCESS_CYCLES));
  assign w_commit   = (r_state == WRITE) && bus.ce_n && r_have_data;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state: ce_n high ends any access; an address latch picks direction.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_latch) w_next = bus.we_n ? READ : WRITE;
      end
      READ, WRITE: begin
        if (bus.ce_n)        w_next = IDLE;
        else if (!bus.adv_n) w_next = bus.we_n ? READ : WRITE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Address, access timer, write capture and transaction counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_acc       <= '0;
      r_rd_word   <= '0;
      r_data      <= '0;
      r_be        <= '0;
      r_have_data <= 1'b0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      if (w_latch) begin
        r_addr      <= w_lat_addr;
        r_acc       <= ACC_W'(1);
        r_have_data <= 1'b0;
        if (bus.we_n) r_rd_word <= r_mem[w_lat_addr];
      end else if ((r_state == READ) && !bus.ce_n && !w_acc_done) begin
        r_acc <= r_acc + ACC_W'(1);
      end
      if ((r_state == WRITE) && !bus.ce_n && bus.adv_n) begin
        r_data      <= bus.dq_in;
        r_be        <= {!bus.ub_n, !bus.lb_n};
        r_have_data <= 1'b1;
      end
      if ((r_state == READ) && bus.ce_n) rd_count <= rd_count + 16'd1;
      if (w_commit)                      wr_count <= wr_count + 16'd1;
    end
  end

  // Storage array: byte-masked commit when a write with captured data ends.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (r_be[0]) r_mem[r_addr][LO_BITS-1:0]         <= r_data[LO_BITS-1:0];
      if (r_be[1]) r_mem[r_addr][DATA_BITS-1:LO_BITS] <= r_data[DATA_BITS-1:LO_BITS];
    end
  end

  assign bus.dq_out = ((r_state == READ) && w_acc_done) ? r_rd_word : INVALID_PATTERN;
  assign bus.dq_oe  = (r_state == READ) && !bus.ce_n && !bus.oe_n && bus.we_n;

`ifdef PSRAM_RESPONDER_CHECK_EN
  logic r_perr;
  logic w_viol;

  // Bus-level rules only apply while this bank is selected; other banks share
  // the same pins. A direction flip is only illegal outside a re-latch.
  assign w_viol = ((r_state == READ) && bus.ce_n && !w_acc_done)
               || (!bus.ce_n && !bus.oe_n && !bus.adv_n)
               || (!bus.ce_n && !bus.oe_n && !bus.we_n)
               || ((r_state == READ)  && !bus.ce_n && bus.adv_n && !bus.we_n)
               || ((r_state == WRITE) && !bus.ce_n && bus.adv_n &&  bus.we_n);

  // Sticky violation flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_perr <= 1'b0;
    else if (w_viol) r_perr <= 1'b1;
  end

  assign protocol_error = r_perr;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_psram_responder.sv
// Scoreboarded bench for psram_responder: the driver pushes expected read-bus
// values while a negedge monitor pops and compares them.
module tb_psram_responder;
  localparam int          DB  = 16;
  localparam int          UB  = 6;
  localparam int          MAB = 10;
  localparam int          AC  = 2;
  localparam logic [15:0] INV = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] rd_count, wr_count;
  logic        protocol_error;

  always #5 clk = ~clk;

  psram_responder_if #(.DATA_BITS(DB), .UPPER_BITS(UB)) bus();

  psram_responder #(
    .DATA_BITS(DB), .UPPER_BITS(UB), .MEM_ADDRESS_BITS(MAB),
    .ACCESS_CYCLES(AC), .INVALID_PATTERN(INV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .rd_count(rd_count), .wr_count(wr_count), .protocol_error(protocol_error)
  );

  // Reference model: word store keyed by aliased address, plus counters.
  logic [15:0] m_mem [int];
  int          m_rd, m_wr;
  logic        m_perr;

  typedef struct { logic [15:0] data; logic oe; } exp_t;
  exp_t sb_q[$];
  logic smp;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: whenever the driver flags a sampling point, compare the bus.
  always @(negedge clk) begin
    exp_t e;
    if (smp) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty actual=%h expected=none", bus.dq_out);
      end else begin
        e = sb_q.pop_front();
        chk("rd_dq_out", {16'h0, bus.dq_out}, {16'h0, e.data});
        chk("rd_dq_oe", {31'h0, bus.dq_oe}, {31'h0, e.oe});
      end
    end
  end

  function automatic int key(input logic [21:0] a);
    return int'(a) & ((1 << MAB) - 1);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.ce_n = 1'b1; bus.adv_n = 1'b1; bus.oe_n = 1'b1; bus.we_n = 1'b1;
    bus.lb_n = 1'b1; bus.ub_n = 1'b1; bus.cram_a = '0; bus.dq_in = '0;
  endtask

  // be = {upper, lower} byte enables, active-high here.
  task automatic wr(input logic [21:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] old;
    tick();
    bus.ce_n = 1'b0; bus.adv_n = 1'b0; bus.we_n = 1'b0; bus.oe_n = 1'b1;
    bus.cram_a = a[21:16]; bus.dq_in = a[15:0];
    tick();
    bus.adv_n = 1'b1; bus.dq_in = d; bus.ub_n = !be[1]; bus.lb_n = !be[0];
    tick();
    idle_inputs();
    old = m_mem.exists(key(a)) ? m_mem[key(a)] : 16'hxxxx;
    m_mem[key(a)] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    m_wr++;
    tick();
  endtask

  // full=0 ends the read after a single edge, before access time is met.
  task automatic rd(input logic [21:0] a, input bit full);
    exp_t e;
    tick();
    bus.ce_n = 1'b0; bus.adv_n = 1'b0; bus.we_n = 1'b1; bus.oe_n = 1'b1;
    bus.cram_a = a[21:16]; bus.dq_in = a[15:0];
    tick();
    bus.adv_n = 1'b1; bus.oe_n = 1'b0; bus.dq_in = '0;
    e.data = INV; e.oe = 1'b1; sb_q.push_back(e);
    smp = 1'b1;
    if (full) begin
      tick();
      e.data = m_mem[key(a)]; e.oe = 1'b1; sb_q.push_back(e);
    end
    @(negedge clk); #1;
    smp = 1'b0;
    idle_inputs();
`ifdef PSRAM_RESPONDER_CHECK_EN
    if (!full) m_perr = 1'b1;
`endif
    m_rd++;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_rd = 0; m_wr = 0; m_perr = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [21:0] a;
    logic [15:0] d;
    smp = 1'b0;
    idle_inputs();
    m_rd = 0; m_wr = 0; m_perr = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    chk("rst_dq_oe",   {31'h0, bus.dq_oe}, 32'h0);
    chk("rst_dq_out",  {16'h0, bus.dq_out}, {16'h0, INV});
    chk("rst_rd_cnt",  {16'h0, rd_count}, 32'h0);
    chk("rst_wr_cnt",  {16'h0, wr_count}, 32'h0);
    chk("rst_perr",    {31'h0, protocol_error}, 32'h0);

    // ce_n low without adv_n in IDLE is ignored: no drive.
    tick();
    bus.ce_n = 1'b0; bus.oe_n = 1'b0;
    tick();
    chk("idle_no_oe", {31'h0, bus.dq_oe}, 32'h0);
    chk("idle_dq_out", {16'h0, bus.dq_out}, {16'h0, INV});
    idle_inputs();

    // Basic write / read-back.
    wr({6'h01, 16'h0005}, 16'h1234, 2'b11);
    rd({6'h01, 16'h0005}, 1'b1);
    chk("t1_wr_cnt", {16'h0, wr_count}, m_wr);
    chk("t1_rd_cnt", {16'h0, rd_count}, m_rd);

    // Upper-byte-only write merges with existing low byte.
    wr({6'h01, 16'h0005}, 16'hAB00, 2'b10);
    rd({6'h01, 16'h0005}, 1'b1);

    // Read ended before access time: invalid pattern, flagged when checking.
    rd({6'h01, 16'h0005}, 1'b0);
    chk("t3_perr",   {31'h0, protocol_error}, {31'h0, m_perr});
    chk("t3_rd_cnt", {16'h0, rd_count}, m_rd);

    // Aliasing beyond the stored range.
    wr({6'h00, 16'h0005}, 16'h5555, 2'b11);
    rd({6'h00, 16'h0405}, 1'b1);
    chk("t4_wr_cnt", {16'h0, wr_count}, m_wr);

    // Reset mid-write after data capture: nothing committed.
    wr({6'h00, 16'h0007}, 16'h7777, 2'b11);
    tick();
    bus.ce_n = 1'b0; bus.adv_n = 1'b0; bus.we_n = 1'b0;
    bus.cram_a = 6'h00; bus.dq_in = 16'h0007;
    tick();
    bus.adv_n = 1'b1; bus.dq_in = 16'h0BAD; bus.ub_n = 1'b0; bus.lb_n = 1'b0;
    tick();
    #1 reset_n = 1'b0;
    m_rd = 0; m_wr = 0; m_perr = 1'b0;
    #1;
    chk("t5_dq_oe",   {31'h0, bus.dq_oe}, 32'h0);
    chk("t5_dq_out",  {16'h0, bus.dq_out}, {16'h0, INV});
    chk("t5_wr_cnt",  {16'h0, wr_count}, 32'h0);
    chk("t5_perr",    {31'h0, protocol_error}, 32'h0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    chk("t5_wr_hold", {16'h0, wr_count}, 32'h0);
    rd({6'h00, 16'h0007}, 1'b1);
    chk("t5_rd_cnt", {16'h0, rd_count}, m_rd);

    // Randomized write/read pairs with one idle cycle between transactions.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a = 22'($urandom);
      d = 16'($urandom);
      wr(a, d, 2'b11);
      rd(a, 1'b1);
    end
    chk("rnd_wr_cnt", {16'h0, wr_count}, 32'd8);
    chk("rnd_rd_cnt", {16'h0, rd_count}, 32'd8);
    chk("rnd_perr",   {31'h0, protocol_error}, 32'h0);

    repeat (2) tick();
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
